// File: rtl/xbar_l2_pkg.sv
// Shared types and sizing helpers for the
// per-bank L2 crossbar arbiter.
package xbar_l2_pkg;

  typedef enum logic {
    PRIO_RR  = 1'b0,
    PRIO_CH1 = 1'b1
  } prio_mode_e;

  function automatic int ptr_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  function automatic int cnt_w(input int max);
    return (max <= 1) ? 1 : $clog2(max + 1);
  endfunction

endpackage

// File: rtl/xbar_l2_bank_arbiter_if.sv
// Master-side request bus and bank-side port
// of one L2 bank arbiter.
interface xbar_l2_bank_arbiter_if
  import xbar_l2_pkg::*;
#(
  parameter int N_MASTER   = 6,
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 64,
  parameter int BE_WIDTH   = DATA_WIDTH / 8,
  parameter int TAG_WIDTH  = DATA_WIDTH / 8
);

  logic [N_MASTER-1:0]                 data_req_i;
  logic [N_MASTER-1:0][ADDR_WIDTH-1:0] data_add_i;
  logic [N_MASTER-1:0]                 data_wen_i;
  logic [N_MASTER-1:0][DATA_WIDTH-1:0] data_wdata_i;
  logic [N_MASTER-1:0][TAG_WIDTH-1:0]  data_wtag_i;
  logic [N_MASTER-1:0][BE_WIDTH-1:0]   data_be_i;
  logic [N_MASTER-1:0]                 data_gnt_o;
  logic [N_MASTER-1:0]                 data_r_valid_o;

  logic                  mem_req_o;
  logic [ADDR_WIDTH-1:0] mem_add_o;
  logic                  mem_wen_o;
  logic [DATA_WIDTH-1:0] mem_wdata_o;
  logic [TAG_WIDTH-1:0]  mem_wtag_o;
  logic [BE_WIDTH-1:0]   mem_be_o;
  logic [N_MASTER-1:0]   mem_ID_o;
  logic                  mem_gnt_i;

  modport slave (
    input  data_req_i, data_add_i, data_wen_i,
    input  data_wdata_i, data_wtag_i, data_be_i,
    output data_gnt_o, data_r_valid_o,
    output mem_req_o, mem_add_o, mem_wen_o,
    output mem_wdata_o, mem_wtag_o, mem_be_o,
    output mem_ID_o,
    input  mem_gnt_i
  );

  modport master (
    output data_req_i, data_add_i, data_wen_i,
    output data_wdata_i, data_wtag_i, data_be_i,
    input  data_gnt_o, data_r_valid_o,
    input  mem_req_o, mem_add_o, mem_wen_o,
    input  mem_wdata_o, mem_wtag_o, mem_be_o,
    input  mem_ID_o,
    output mem_gnt_i
  );

endinterface

// File: rtl/xbar_l2_bank_arbiter_rr.sv
// Generic N-input round-robin arbiter; the
// pointer moves past the winner when en_i.
module l2_rr_arbiter
  import xbar_l2_pkg::*;
#(
  parameter  int N  = 4,
  localparam int IW = ptr_w(N)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [N-1:0]  req_i,
  input  logic          en_i,
  output logic [N-1:0]  gnt_o,
  output logic [IW-1:0] idx_o
);

  logic [IW-1:0] ptr_q, ptr_d;
  logic          found;
  int            j;

  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    found = 1'b0;
    j     = 0;
    for (int k = 0; k < N; k++) begin
      j = int'(ptr_q) + k;
      if (j >= N) j = j - N;
      if (!found && req_i[j]) begin
        found    = 1'b1;
        gnt_o[j] = 1'b1;
        idx_o    = IW'(j);
      end
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (en_i) begin
      ptr_d = (idx_o == IW'(N - 1)) ? '0
            : idx_o + IW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ptr_q <= '0;
    else        ptr_q <= ptr_d;
  end

endmodule

// File: rtl/xbar_l2_bank_arbiter.sv
// Per-bank L2 request arbiter: RR or CH1-priority
// with CH0 starvation guard, plus r_valid ID pipe.
module xbar_l2_bank_arbiter
  import xbar_l2_pkg::*;
#(
  parameter int         N_CH0       = 4,
  parameter int         N_CH1       = 2,
  parameter int         ADDR_WIDTH  = 12,
  parameter int         DATA_WIDTH  = 64,
  parameter int         BE_WIDTH    = DATA_WIDTH / 8,
  parameter int         TAG_WIDTH   = DATA_WIDTH / 8,
  parameter prio_mode_e PRIO_MODE   = PRIO_CH1,
  parameter int         STARVE_MAX  = 3,
  parameter int         MEM_LATENCY = 1
) (
  input logic                   clk,
  input logic                   rst_n,
  xbar_l2_bank_arbiter_if.slave bus
);

  localparam int N_MASTER = N_CH0 + N_CH1;
  localparam int ID_WIDTH = N_MASTER;
  localparam int PW       = ptr_w(N_MASTER);

  logic                req_any;
  logic                hs;
  logic [PW-1:0]       win_idx;
  logic [ID_WIDTH-1:0] win_oh;

  assign req_any = |bus.data_req_i;
  assign hs      = req_any & bus.mem_gnt_i;

  if (PRIO_MODE == PRIO_RR || N_CH1 == 0) begin : g_flat
    l2_rr_arbiter #(.N(N_MASTER)) u_arb (
      .clk   (clk),
      .rst_n (rst_n),
      .req_i (bus.data_req_i),
      .en_i  (hs),
      .gnt_o (win_oh),
      .idx_o (win_idx)
    );
  end else begin : g_prio
    localparam int CW = cnt_w(STARVE_MAX);
    localparam int W0 = ptr_w(N_CH0);
    localparam int W1 = ptr_w(N_CH1);

    logic [N_CH0-1:0] gnt0;
    logic [N_CH1-1:0] gnt1;
    logic [W0-1:0]    idx0;
    logic [W1-1:0]    idx1;
    logic             ch0_any, ch1_any, sel0;
    logic [CW-1:0]    starve_q, starve_d;

    assign ch0_any = |bus.data_req_i[N_CH0-1:0];
    assign ch1_any = |bus.data_req_i[N_MASTER-1:N_CH0];
    // CH0 may only pre-empt CH1 once it has been denied long enough
    assign sel0 = ch0_any &
                  (~ch1_any | (starve_q == CW'(STARVE_MAX)));

    l2_rr_arbiter #(.N(N_CH0)) u_arb0 (
      .clk   (clk),
      .rst_n (rst_n),
      .req_i (bus.data_req_i[N_CH0-1:0]),
      .en_i  (hs & sel0),
      .gnt_o (gnt0),
      .idx_o (idx0)
    );

    l2_rr_arbiter #(.N(N_CH1)) u_arb1 (
      .clk   (clk),
      .rst_n (rst_n),
      .req_i (bus.data_req_i[N_MASTER-1:N_CH0]),
      .en_i  (hs & ~sel0),
      .gnt_o (gnt1),
      .idx_o (idx1)
    );

    assign win_oh  = sel0 ? {{N_CH1{1'b0}}, gnt0}
                          : {gnt1, {N_CH0{1'b0}}};
    assign win_idx = sel0 ? PW'(idx0)
                          : PW'(N_CH0) + PW'(idx1);

    always_comb begin
      starve_d = starve_q;
      if (!ch0_any || (hs && sel0)) begin
        starve_d = '0;
      end else if (starve_q != CW'(STARVE_MAX)) begin
        starve_d = starve_q + CW'(1);
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) starve_q <= '0;
      else        starve_q <= starve_d;
    end
  end

  assign bus.mem_req_o   = req_any;
  assign bus.mem_ID_o    = win_oh;
  assign bus.data_gnt_o  = hs ? win_oh : '0;
  assign bus.mem_add_o   = bus.data_add_i[win_idx];
  assign bus.mem_wen_o   = bus.data_wen_i[win_idx];
  assign bus.mem_wdata_o = bus.data_wdata_i[win_idx];
  assign bus.mem_wtag_o  = bus.data_wtag_i[win_idx];
  assign bus.mem_be_o    = bus.data_be_i[win_idx];

  logic [MEM_LATENCY-1:0]               vld_q;
  logic [MEM_LATENCY-1:0][ID_WIDTH-1:0] id_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q <= '0;
      id_q  <= '0;
    end else begin
      vld_q[0] <= hs;
      id_q[0]  <= hs ? win_oh : '0;
      for (int s = 1; s < MEM_LATENCY; s++) begin
        vld_q[s] <= vld_q[s-1];
        id_q[s]  <= id_q[s-1];
      end
    end
  end

  assign bus.data_r_valid_o = vld_q[MEM_LATENCY-1]
                            ? id_q[MEM_LATENCY-1] : '0;

endmodule

// File: doc/xbar_l2_bank_arbiter.md
Name: xbar_l2_bank_arbiter

Overview:
- Per-bank request arbiter for the next-generation L2 crossbar; one instance sits in front of each L2 bank.
- Arbitrates N_CH0 cluster-class masters and N_CH1 FC/host-class masters onto a single bank port and honours real memory backpressure (mem gnt is not tied high).
- Selectable flat round-robin or CH1-priority mode with a CH0 starvation guard.
- Generates one-hot response-valid per master through an ID pipeline of configurable memory latency.

Parameters:
- N_CH0, 4, number of CH0-class masters, >=1
- N_CH1, 2, number of CH1-class masters, >=0
- N_MASTER, N_CH0+N_CH1, total masters (derived)
- ID_WIDTH, N_MASTER, one-hot ID width (derived)
- ADDR_WIDTH, 12, bank row address width
- DATA_WIDTH, 64, data width
- BE_WIDTH, DATA_WIDTH/8, byte-enable width
- TAG_WIDTH, DATA_WIDTH/8, tag width
- PRIO_MODE, 1, 0 = flat round-robin over all masters; 1 = CH1 priority with CH0 starvation guard
- STARVE_MAX, 3, consecutive denied CH0 cycles before CH0 is forced to win (mode 1 only), >=1
- MEM_LATENCY, 1, cycles from handshake to r_valid, >=1

Ports:
- clk  in  1  clock
- rst_n  in  1  reset
- data_req_i  in  N_MASTER  master requests
- data_add_i  in  N_MASTER x ADDR_WIDTH  row address
- data_wen_i  in  N_MASTER  1 = load, 0 = store
- data_wdata_i  in  N_MASTER x DATA_WIDTH  write data
- data_wtag_i  in  N_MASTER x TAG_WIDTH  write tag
- data_be_i  in  N_MASTER x BE_WIDTH  byte enables
- data_gnt_o  out  N_MASTER  one-hot grant
- data_r_valid_o  out  N_MASTER  one-hot response valid
- mem_req_o  out  1  bank request
- mem_add_o, mem_wen_o, mem_wdata_o, mem_wtag_o, mem_be_o  out  widths as above  winner payload
- mem_ID_o  out  ID_WIDTH  one-hot ID of the winner
- mem_gnt_i  in  1  bank accepts the request

Reset: one clock (clk); reset is asynchronous and active-low (rst_n).

Behaviour:
- Request path is combinational, zero latency.
  - mem_req_o = |data_req_i.
  - Payload and mem_ID_o are muxed from the winner.
  - data_gnt_o[w] = mem_gnt_i & mem_req_o & (w == winner); all other grant bits are 0.
- Handshake occurs when mem_req_o & mem_gnt_i. Arbitration state updates only on a handshake, except the starvation counter (see below).
- Mode 0: a single round-robin pointer over all N_MASTER. The winner is the first requester at or after the pointer, wrapping. On handshake the pointer becomes winner+1 mod N_MASTER.
- Mode 1: separate round-robin pointers, one per class.
  - CH1 wins whenever any CH1 request is present, unless starve_cnt == STARVE_MAX and a CH0 request is present; then CH0 wins.
  - If only one class requests, that class wins.
  - Only the pointer of the winning class advances on handshake.
  - N_CH1 == 0 degenerates to mode 0.
- Starvation counter (mode 1), saturating at STARVE_MAX:
  - Increments each cycle a CH0 request is present and no CH0 handshake occurs.
  - Clears on a CH0 handshake, or in any cycle with no CH0 request.
- Memory backpressure: mem_gnt_i low stalls all pointers and holds the winner stable while the same requests persist. A master may deassert without penalty.
- Response pipeline: MEM_LATENCY stages of {valid, ID}.
  - Stage 0 loads {1, winner one-hot} on handshake, else {0, 0}.
  - data_r_valid_o = last stage valid ? last stage ID : 0.
  - Loads and stores both receive exactly one r_valid, exactly MEM_LATENCY cycles after their gnt.
  - Back-to-back handshakes give back-to-back r_valids in order.
- Reset values: all pointers 0, starve_cnt 0, pipeline cleared.
  - data_r_valid_o = 0.
  - Combinational outputs follow inputs; with no requests data_gnt_o = 0 and mem_req_o = 0.
- Reset asserted mid-operation drops all in-flight responses; no r_valid is produced for them.
- Masters must hold request and payload stable until granted.

Decomposition:
- Package xbar_l2_pkg holds:
  - prio_mode_e enumeration (PRIO_RR, PRIO_CH1).
  - Helper constant functions for pointer width and counter width ($clog2 with a minimum of 1).
- Sub-module l2_rr_arbiter: generic N-input round-robin with a pointer register. Inputs req, handshake enable. Outputs one-hot gnt and index. Instantiated once per class in mode 1, or once in mode 0.

Test Plan:
- Mode 0, all 6 masters request continuously, mem_gnt_i = 1 -> grants in order 0,1,2,3,4,5,0; r_valid for each appears 1 cycle after its grant.
- mem_gnt_i = 0 for 3 cycles with masters 1 and 3 requesting -> data_gnt_o = 0, mem_ID_o = 6'b000010 stable; gnt goes to master 1 on the cycle mem_gnt_i rises, then master 3.
- Mode 1, masters 0 and 4 request continuously -> master 4 granted 3 cycles, master 0 on cycle 4, then master 4 again; starve_cnt sequence 1,2,3,0.
- Mode 1, only master 5 (CH1) requests, CH0 idle -> master 5 granted every cycle; starve_cnt stays 0.
- MEM_LATENCY = 3, store by master 2 then load by master 3 on consecutive cycles -> r_valid_o = 6'b000100 then 6'b001000, 3 cycles after each grant.
- rst_n low one cycle after a handshake with MEM_LATENCY = 2 -> no r_valid emitted; after release, pointer is 0 and master 0 wins first.
